// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal register and anything that drives it.
// Holds the 3-bit operation-select encoding so the register, its bench and
// future blocks all agree on what each mode value means.
package universal_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_UP   = 3'b100,
        MODE_DOWN = 3'b101,
        MODE_ROTR = 3'b110,
        MODE_ROTL = 3'b111
    } mode_e;

endpackage : universal_register_pkg

// File: rtl/universal_register_cell.sv
// One bit of the universal register.
// Stores a single bit with synchronous clear (wins) and preset, and picks its
// next value from the candidate bits supplied by the top level.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous clear, active-high, highest priority
//   pst_i        synchronous preset, active-high
//   en_i         operation enable; 0 holds the bit
//   mode_i       operation select
//   shr_bit_i    value for shift right (left neighbour or sin_r at the MSB)
//   shl_bit_i    value for shift left (right neighbour or sin_l at the LSB)
//   rotr_bit_i   value for rotate right
//   rotl_bit_i   value for rotate left
//   ld_bit_i     parallel load data bit
//   inc_bit_i    this bit of q+1
//   dec_bit_i    this bit of q-1
//   q_o          stored bit
module universal_register_cell
    import universal_register_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  pst_i,
    input  logic  en_i,
    input  mode_e mode_i,
    input  logic  shr_bit_i,
    input  logic  shl_bit_i,
    input  logic  rotr_bit_i,
    input  logic  rotl_bit_i,
    input  logic  ld_bit_i,
    input  logic  inc_bit_i,
    input  logic  dec_bit_i,
    output logic  q_o
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        bit_d = bit_q;
        if (en_i) begin
            case (mode_i)
                MODE_HOLD: bit_d = bit_q;
                MODE_SHR:  bit_d = shr_bit_i;
                MODE_SHL:  bit_d = shl_bit_i;
                MODE_LOAD: bit_d = ld_bit_i;
                MODE_UP:   bit_d = inc_bit_i;
                MODE_DOWN: bit_d = dec_bit_i;
                MODE_ROTR: bit_d = rotr_bit_i;
                MODE_ROTL: bit_d = rotl_bit_i;
                default:   bit_d = bit_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_q <= 1'b0;
        end else if (pst_i) begin
            bit_q <= 1'b1;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q_o = bit_q;

endmodule : universal_register_cell

// File: rtl/universal_register.sv
// Universal register: hold, shift left/right, rotate left/right, parallel
// load and up/down count, with synchronous reset and preset.
// Ports:
//   clk    clock, all updates on the rising edge
//   rst    synchronous reset, active-high, forces all zeros (beats pst)
//   pst    synchronous preset, active-high, forces all ones
//   en     operation enable; 0 holds q whatever the mode
//   mode   operation select (see universal_register_pkg::mode_e)
//   d      parallel load data
//   sin_r  serial input entering q[WIDTH-1] on shift right
//   sin_l  serial input entering q[0] on shift left
//   q      register contents
//   tc     terminal count: counting up at all ones, or down at zero
module universal_register
    import universal_register_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    mode_e            mode_sel;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;

    assign mode_sel = mode_e'(mode);

    // The counter is a word-wide carry chain, so it lives here rather than
    // in the cells; each cell just receives its bit of the result.
    assign inc_val = q + WIDTH'(1);
    assign dec_val = q - WIDTH'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shr_src;
        logic shl_src;
        logic rotr_src;
        logic rotl_src;

        if (i == WIDTH - 1) begin : g_msb
            assign shr_src  = sin_r;
            assign rotr_src = q[0];
        end else begin : g_mid_r
            assign shr_src  = q[i+1];
            assign rotr_src = q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign shl_src  = sin_l;
            assign rotl_src = q[WIDTH-1];
        end else begin : g_mid_l
            assign shl_src  = q[i-1];
            assign rotl_src = q[i-1];
        end

        universal_register_cell u_cell (
            .clk_i      (clk),
            .rst_i      (rst),
            .pst_i      (pst),
            .en_i       (en),
            .mode_i     (mode_sel),
            .shr_bit_i  (shr_src),
            .shl_bit_i  (shl_src),
            .rotr_bit_i (rotr_src),
            .rotl_bit_i (rotl_src),
            .ld_bit_i   (d[i]),
            .inc_bit_i  (inc_val[i]),
            .dec_bit_i  (dec_val[i]),
            .q_o        (q[i])
        );
    end

    // tc is forced low while reset or preset is asserted, since q is about
    // to be overwritten and is not a meaningful count boundary.
    always_comb begin
        tc = 1'b0;
        if (en && !rst && !pst) begin
            if (mode_sel == MODE_UP && (&q)) begin
                tc = 1'b1;
            end else if (mode_sel == MODE_DOWN && q == '0) begin
                tc = 1'b1;
            end
        end
    end

endmodule : universal_register

// File: tb/tb_universal_register.sv
// Bench for universal_register (WIDTH=4): directed scenarios followed by
// random operation sequences, all scored against an arithmetic model.
module tb_universal_register;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst, pst, en, sin_r, sin_l;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc;

    int total = 0;
    int bad   = 0;
    int model_q = 0;

    universal_register #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .pst   (pst),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .q     (q),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Next value from the operation rules, using integer arithmetic on the
    // numeric value of q.
    function automatic int ref_next(int cur, bit r, bit p, bit e, int m, int dv, bit sr, bit sl);
        if (r) return 0;
        if (p) return MOD - 1;
        if (!e) return cur;
        case (m)
            0: return cur;
            1: return (cur / 2) + (sr ? MOD / 2 : 0);
            2: return ((cur * 2) % MOD) + (sl ? 1 : 0);
            3: return dv;
            4: return (cur + 1) % MOD;
            5: return (cur + MOD - 1) % MOD;
            6: return (cur / 2) + ((cur % 2) * (MOD / 2));
            7: return ((cur * 2) % MOD) + (cur / (MOD / 2));
            default: return cur;
        endcase
    endfunction

    function automatic bit ref_tc(int cur, bit r, bit p, bit e, int m);
        if (r || p || !e) return 1'b0;
        return (m == 4 && cur == MOD - 1) || (m == 5 && cur == 0);
    endfunction

    // Apply one set of inputs for one clock edge; check tc before the edge
    // and q after it.
    task automatic drive(input string tag, input bit r, input bit p, input bit e,
                         input int m, input int dv, input bit sr, input bit sl);
        @(negedge clk);
        rst = r; pst = p; en = e; mode = m[2:0]; d = dv[W-1:0]; sin_r = sr; sin_l = sl;
        #1;
        check({tag, ".tc"}, {31'd0, tc}, {31'd0, ref_tc(model_q, r, p, e, m)});
        @(posedge clk);
        model_q = ref_next(model_q, r, p, e, m, dv, sr, sl);
        #1;
        check({tag, ".q"}, {28'd0, q}, model_q);
    endtask

    initial begin
        rst = 1'b1; pst = 1'b0; en = 1'b0; mode = 3'd0; d = '0; sin_r = 1'b0; sin_l = 1'b0;

        // reset state
        drive("reset", 1, 0, 1, 4, 5, 1, 1);
        check("reset_q", {28'd0, q}, 32'h0);
        #1;
        check("reset_tc", {31'd0, tc}, 32'h0);

        // rst beats pst, then pst alone
        drive("ld1010", 0, 0, 1, 3, 4'b1010, 0, 0);
        drive("rstpst", 1, 1, 1, 3, 4'b0110, 1, 1);
        check("rstpst_lit", {28'd0, q}, 32'b0000);
        drive("pst", 0, 1, 0, 0, 0, 0, 0);
        check("pst_lit", {28'd0, q}, 32'b1111);

        // load then shift right twice
        drive("ld1011", 0, 0, 1, 3, 4'b1011, 0, 0);
        check("ld_lit", {28'd0, q}, 32'b1011);
        drive("shr1", 0, 0, 1, 1, 0, 0, 1);
        check("shr1_lit", {28'd0, q}, 32'b0101);
        drive("shr2", 0, 0, 1, 1, 0, 0, 1);
        check("shr2_lit", {28'd0, q}, 32'b0010);

        // shift left, rotate left, rotate right
        drive("ld0110", 0, 0, 1, 3, 4'b0110, 0, 0);
        drive("shl", 0, 0, 1, 2, 0, 0, 1);
        check("shl_lit", {28'd0, q}, 32'b1101);
        drive("rotl", 0, 0, 1, 7, 0, 0, 0);
        check("rotl_lit", {28'd0, q}, 32'b1011);
        drive("rotr", 0, 0, 1, 6, 0, 0, 0);
        check("rotr_lit", {28'd0, q}, 32'b1101);

        // count up through wrap, then count down from zero
        drive("ld1110", 0, 0, 1, 3, 4'b1110, 0, 0);
        drive("up1", 0, 0, 1, 4, 0, 0, 0);
        check("up1_lit", {28'd0, q}, 32'b1111);
        drive("up2", 0, 0, 1, 4, 0, 0, 0);
        check("up2_lit", {28'd0, q}, 32'b0000);
        mode = 3'b101;
        #1;
        check("dn_tc_lit", {31'd0, tc}, 32'h1);
        drive("dn", 0, 0, 1, 5, 0, 0, 0);
        check("dn_lit", {28'd0, q}, 32'b1111);

        // enable low holds for three edges in any mode
        drive("ld0101", 0, 0, 1, 3, 4'b0101, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive("hold", 0, 0, 0, 4 + i, 4'b1111, 1, 1);
            check("hold_lit", {28'd0, q}, 32'b0101);
        end

        // reset aborts a count
        drive("ld0011", 0, 0, 1, 3, 4'b0011, 0, 0);
        drive("cnt", 0, 0, 1, 4, 0, 0, 0);
        drive("cnt_rst", 1, 0, 1, 4, 0, 0, 0);
        check("cnt_rst_lit", {28'd0, q}, 32'b0000);
        drive("cnt_after", 0, 0, 1, 4, 0, 0, 0);
        check("cnt_after_lit", {28'd0, q}, 32'b0001);

        // random operation sequences
        for (int i = 0; i < 600; i++) begin
            drive("rand",
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, MOD - 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_universal_register

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 Parameter WIDTH, default 4; register width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 pst  input  1  preset; synchronous, active-high; forces all ones.
REQ-005 en  input  1  operation enable; 0 = hold regardless of mode.
REQ-006 mode  input  3  operation select, encoding per REQ-011.
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 sin_r  input  1  serial in for shift right; enters q[WIDTH-1].
REQ-009 sin_l  input  1  serial in for shift left; enters q[0].
REQ-010 q  output  WIDTH  register contents; tc  output  1  terminal count flag.

Function
REQ-011 mode encoding: 000 hold, 001 shift right, 010 shift left, 011 parallel load, 100 count up, 101 count down, 110 rotate right, 111 rotate left.
REQ-012 Per-edge priority: rst, then pst, then en=0 (hold), then mode operation.
REQ-013 rst and pst both high: rst wins; q becomes all zeros.
REQ-014 Shift right: q <= {sin_r, q[WIDTH-1:1]}; shift left: q <= {q[WIDTH-2:0], sin_l}.
REQ-015 Rotate right: q <= {q[0], q[WIDTH-1:1]}; rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; serial inputs ignored.
REQ-016 Parallel load: q <= d, latency one clock edge.
REQ-017 Count up: q <= q + 1 modulo 2^WIDTH; all ones wraps to zero.
REQ-018 Count down: q <= q - 1 modulo 2^WIDTH; zero wraps to all ones.
REQ-019 tc is combinational from q, mode, en: 1 when en=1 and (mode=100 and q all ones, or mode=101 and q zero); otherwise 0.
REQ-020 tc is 0 while rst or pst is high.
REQ-021 Mode change takes effect on the next edge; no pipeline, no internal state other than q.
REQ-022 Unknown/X on mode when en=1 is not supported; no defined response required.

Reset
REQ-023 On a rising clk edge with rst=1, q = 0 (all WIDTH bits), independent of all other inputs.
REQ-024 tc = 0 during and immediately after reset until en and mode satisfy REQ-019.
REQ-025 Reset asserted mid-count or mid-shift aborts the operation on that edge; no partial update.
REQ-026 No asynchronous path: rst/pst changes between edges do not alter q.

Structure
REQ-027 Mode encoding constants (MODE_HOLD .. MODE_ROTL) reside in a shared package/include for reuse by the bench and future blocks.
REQ-028 One sub-module, universal_register_cell: single bit storage with synchronous clear/preset and next-value mux; WIDTH instances generated; counter next-value computed at top level.

Verification (WIDTH=4)
REQ-029 rst=1 and pst=1 from q=1010 -> q=0000 after one edge; rst=0, pst=1 -> q=1111 after next edge.
REQ-030 en=1, mode=011, d=1011 -> q=1011; then mode=001, sin_r=0 for two edges -> q=0101 then 0010.
REQ-031 q=0110, mode=010, sin_l=1 -> q=1101; mode=111 -> q=1011; mode=110 -> q=1101.
REQ-032 q=1110, mode=100 -> q=1111 with tc=1, next edge q=0000 with tc=0; mode=101 from 0000 -> tc=1 before edge, q=1111 after.
REQ-033 q=0101, en=0, any mode for three edges -> q stays 0101, tc=0.
REQ-034 Counting up from 0011, rst pulsed for one edge -> q=0000, next edge with rst=0 -> q=0001.
